inst_fetch_queue: RTL and testbench

Parametrised instruction fetch queue between the PC/fetch stage and the decoder. Decouples instruction SRAM return from decode stalls, with configurable depth, payload width, almost-full margin and an optional empty-queue bypass. Holds {pc, inst} pairs in order and drops everything on a pipeline flush, so the fetch stage can run ahead of decode without losing instructions.

---
 rtl/inst_fetch_queue.sv | 143 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// In-order queue of {pc, inst} pairs between the fetch stage and the decoder.
// When decode stalls, the fetch stage can keep running ahead and park its
// returned instructions here. A pipeline flush discards every entry.
//
// When BYPASS = 1 and the queue is empty, an offered entry appears on the pop
// port in the same cycle. If decode takes it in that cycle, it is never stored.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//   DATA_W     instruction payload width (the PC is always 32 bits)
//   AF_MARGIN  almost_full_o asserts when count >= DEPTH - AF_MARGIN
//   BYPASS     1 = empty-queue combinational bypass, 0 = always registered
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         drop all entries and refuse/hide traffic this cycle
//   push_valid_i    fetch offers {push_pc_i, push_inst_i}
//   push_ready_o    queue can accept an entry (occupancy < DEPTH)
//   pop_valid_o     head entry is presented to decode
//   pop_ready_i     decode consumes the head this cycle
//   pop_pc_o        head PC
//   pop_inst_o      head instruction
//   count_o         registered occupancy
//   almost_full_o   registered occupancy threshold for the PC stage
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 32,
  parameter int AF_MARGIN = 2,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [31:0]              push_pc_i,
  input  logic [DATA_W-1:0]        push_inst_i,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output logic [31:0]              pop_pc_o,
  output logic [DATA_W-1:0]        pop_inst_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     almost_full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);

  typedef struct packed {
    logic [31:0]       pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;

  logic            empty;
  logic            full;
  logic            push_fire;
  logic            pop_fire;
  logic            pass_through;
  logic            write_en;
  logic            read_adv;
  entry_t          push_entry;

  assign empty      = (cnt == '0);
  assign full       = (cnt == FULL_LEVEL);
  assign push_entry = '{pc: push_pc_i, inst: push_inst_i};

  // Handshake signals. push_ready_o looks only at the registered occupancy,
  // so there is no combinational path from pop_ready_i back to fetch.
  assign push_ready_o = !flush_i && !full;
  assign pop_valid_o  = !flush_i && (!empty || (BYPASS && push_valid_i));

  assign push_fire = push_valid_i && push_ready_o;
  assign pop_fire  = pop_valid_o && pop_ready_i;

  // An empty queue that pops can only be popping the bypassed push, so that
  // entry passes straight through and the storage is left untouched.
  assign pass_through = empty && push_fire && pop_fire;
  assign write_en     = push_fire && !pass_through;
  assign read_adv     = pop_fire && !empty;

  // Pop data: stored head, or the live push data under bypass.
  // NOTE: every output of this block gets a value on every path; a missing
  // default in combinational logic would infer a latch.
  always_comb begin
    pop_pc_o   = mem[rd_ptr].pc;
    pop_inst_o = mem[rd_ptr].inst;
    if (BYPASS && empty) begin
      pop_pc_o   = push_pc_i;
      pop_inst_o = push_inst_i;
    end
  end

  // NOTE: the storage array has no reset. Occupancy and pointers decide which
  // slots are meaningful, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointers wrap modulo DEPTH because DEPTH is a power of two.
      if (write_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (read_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({write_en, read_adv})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count_o       = cnt;
  assign almost_full_o = (cnt >= AF_LEVEL);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue. Two instances are built with DEPTH=8,
// AF_MARGIN=2: u_byp with BYPASS=1 (used by most scenarios) and u_reg with
// BYPASS=0 (used for the registered-latency comparison). Inputs change 1 ns
// after a rising edge; outputs are checked 2 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst_n;

  // Stimulus for the bypassing instance.
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_inst;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_pc;
  logic [31:0] pop_inst;
  logic [3:0]  count;
  logic        almost_full;

  // Stimulus for the registered instance.
  logic        r_flush;
  logic        r_push_valid;
  logic        r_push_ready;
  logic [31:0] r_push_pc;
  logic [31:0] r_push_inst;
  logic        r_pop_valid;
  logic        r_pop_ready;
  logic [31:0] r_pop_pc;
  logic [31:0] r_pop_inst;
  logic [3:0]  r_count;
  logic        r_almost_full;

  int tests;
  int fails;

  inst_fetch_queue #(.DEPTH(8), .DATA_W(32), .AF_MARGIN(2), .BYPASS(1'b1)) u_byp (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_pc_i    (push_pc),
    .push_inst_i  (push_inst),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (pop_ready),
    .pop_pc_o     (pop_pc),
    .pop_inst_o   (pop_inst),
    .count_o      (count),
    .almost_full_o(almost_full)
  );

  inst_fetch_queue #(.DEPTH(8), .DATA_W(32), .AF_MARGIN(2), .BYPASS(1'b0)) u_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (r_flush),
    .push_valid_i (r_push_valid),
    .push_ready_o (r_push_ready),
    .push_pc_i    (r_push_pc),
    .push_inst_i  (r_push_inst),
    .pop_valid_o  (r_pop_valid),
    .pop_ready_i  (r_pop_ready),
    .pop_pc_o     (r_pop_pc),
    .pop_inst_o   (r_pop_inst),
    .count_o      (r_count),
    .almost_full_o(r_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry with pop_ready low and let it be accepted.
  task automatic push_one(input logic [31:0] pc);
    push_valid = 1'b1;
    push_pc    = pc;
    push_inst  = inst_of(pc);
    pop_ready  = 1'b0;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0; push_valid = 1'b0; push_pc = '0; push_inst = '0; pop_ready = 1'b0;
    r_flush = 1'b0; r_push_valid = 1'b0; r_push_pc = '0; r_push_inst = '0; r_pop_ready = 1'b0;
    repeat (3) tick();
    #1;
    tests++;
    if (count !== 4'd0 || push_ready !== 1'b1 || pop_valid !== 1'b0 || almost_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: count=%0d push_ready=%b pop_valid=%b af=%b, want 0 1 0 0",
               count, push_ready, pop_valid, almost_full);
    end
    rst_n = 1'b1;
    tick();
    #1;
    tests++;
    if (count !== 4'd0 || push_ready !== 1'b1 || pop_valid !== 1'b0 || almost_full !== 1'b0 ||
        r_count !== 4'd0 || r_push_ready !== 1'b1 || r_pop_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: count=%0d push_ready=%b pop_valid=%b af=%b r_count=%0d, want 0 1 0 0 0",
               count, push_ready, pop_valid, almost_full, r_count);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_pc;
    pop_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_valid = 1'b1;
      push_pc    = 32'hBFC0_0000 + 32'(4 * i);
      push_inst  = inst_of(push_pc);
      tick();
      #1;
      tests++;
      if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6) || push_ready !== (i + 1 < 8)) begin
        fails++;
        $display("FAIL fill_%0d: count=%0d af=%b push_ready=%b, want %0d %b %b",
                 i, count, almost_full, push_ready, i + 1, (i + 1 >= 6), (i + 1 < 8));
      end
    end
    // Ninth offer must be held while full.
    push_pc   = 32'hBFC0_0020;
    push_inst = inst_of(push_pc);
    tick();
    #1;
    tests++;
    if (count !== 4'd8 || push_ready !== 1'b0 || pop_pc !== 32'hBFC0_0000) begin
      fails++;
      $display("FAIL fill_ninth_held: count=%0d push_ready=%b head=%h, want 8 0 bfc00000",
               count, push_ready, pop_pc);
    end
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'hBFC0_0000 + 32'(4 * i);
      #1;
      tests++;
      if (pop_valid !== 1'b1 || pop_pc !== exp_pc || pop_inst !== inst_of(exp_pc)) begin
        fails++;
        $display("FAIL drain_%0d: valid=%b pc=%h inst=%h, want 1 %h %h",
                 i, pop_valid, pop_pc, pop_inst, exp_pc, inst_of(exp_pc));
      end
      tick();
      #1;
      tests++;
      if (count !== 4'(7 - i) || almost_full !== (7 - i >= 6)) begin
        fails++;
        $display("FAIL drain_count_%0d: count=%0d af=%b, want %0d %b",
                 i, count, almost_full, 7 - i, (7 - i >= 6));
      end
      #(-1ns + 1ns);
    end
    pop_ready = 1'b0;
    #1;
    tests++;
    if (pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain_empty: pop_valid=%b push_ready=%b, want 0 1", pop_valid, push_ready);
    end
    tick();
  endtask

  task automatic test_bypass();
    // BYPASS=1: same-cycle pass-through, nothing stored.
    push_valid = 1'b1;
    push_pc    = 32'hBFC0_0100;
    push_inst  = 32'h2402_0001;
    pop_ready  = 1'b1;
    #1;
    tests++;
    if (pop_valid !== 1'b1 || pop_inst !== 32'h2402_0001 || pop_pc !== 32'hBFC0_0100) begin
      fails++;
      $display("FAIL bypass_same_cycle: valid=%b pc=%h inst=%h, want 1 bfc00100 24020001",
               pop_valid, pop_pc, pop_inst);
    end
    tick();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    #1;
    tests++;
    if (count !== 4'd0 || pop_valid !== 1'b0) begin
      fails++;
      $display("FAIL bypass_not_stored: count=%0d pop_valid=%b, want 0 0", count, pop_valid);
    end
    // BYPASS=0: the same offer only appears after the edge.
    r_push_valid = 1'b1;
    r_push_pc    = 32'hBFC0_0100;
    r_push_inst  = 32'h2402_0001;
    r_pop_ready  = 1'b1;
    #1;
    tests++;
    if (r_pop_valid !== 1'b0) begin
      fails++;
      $display("FAIL nobypass_same_cycle: pop_valid=%b, want 0", r_pop_valid);
    end
    tick();
    r_push_valid = 1'b0;
    #1;
    tests++;
    if (r_pop_valid !== 1'b1 || r_pop_inst !== 32'h2402_0001 || r_pop_pc !== 32'hBFC0_0100 ||
        r_count !== 4'd1) begin
      fails++;
      $display("FAIL nobypass_next_cycle: valid=%b pc=%h inst=%h count=%0d, want 1 bfc00100 24020001 1",
               r_pop_valid, r_pop_pc, r_pop_inst, r_count);
    end
    tick();
    r_pop_ready = 1'b0;
    #1;
    tests++;
    if (r_count !== 4'd0 || r_pop_valid !== 1'b0) begin
      fails++;
      $display("FAIL nobypass_drained: count=%0d pop_valid=%b, want 0 0", r_count, r_pop_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] next_push;
    logic [31:0] exp_head;
    logic [31:0] prev_pc;
    next_push = 32'h0000_1000;
    exp_head  = 32'h0000_1000;
    for (int i = 0; i < 3; i++) begin
      push_one(next_push);
      next_push += 32'd4;
    end
    prev_pc = exp_head - 32'd4;
    for (int i = 0; i < 20; i++) begin
      push_valid = 1'b1;
      push_pc    = next_push;
      push_inst  = inst_of(next_push);
      pop_ready  = 1'b1;
      #1;
      tests++;
      if (pop_valid !== 1'b1 || pop_pc !== exp_head || pop_pc !== prev_pc + 32'd4 ||
          pop_inst !== inst_of(exp_head)) begin
        fails++;
        $display("FAIL b2b_head_%0d: valid=%b pc=%h inst=%h, want 1 %h %h",
                 i, pop_valid, pop_pc, pop_inst, exp_head, inst_of(exp_head));
      end
      prev_pc = exp_head;
      tick();
      #1;
      tests++;
      if (count !== 4'd3) begin
        fails++;
        $display("FAIL b2b_count_%0d: count=%0d, want 3", i, count);
      end
      next_push += 32'd4;
      exp_head  += 32'd4;
    end
    push_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (pop_pc !== exp_head) begin
        fails++;
        $display("FAIL b2b_drain_%0d: pc=%h, want %h", i, pop_pc, exp_head);
      end
      exp_head += 32'd4;
      tick();
    end
    pop_ready = 1'b0;
    #1;
    tests++;
    if (count !== 4'd0) begin
      fails++;
      $display("FAIL b2b_end_count: count=%0d, want 0", count);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      push_one(32'h0000_2000 + 32'(4 * i));
    end
    flush      = 1'b1;
    push_valid = 1'b1;
    push_pc    = 32'hDEAD_0000;
    push_inst  = inst_of(32'hDEAD_0000);
    pop_ready  = 1'b1;
    #1;
    tests++;
    if (count !== 4'd5 || pop_valid !== 1'b0 || push_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_cycle: count=%0d pop_valid=%b push_ready=%b, want 5 0 0",
               count, pop_valid, push_ready);
    end
    tick();
    flush      = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    #1;
    tests++;
    if (count !== 4'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_after: count=%0d pop_valid=%b push_ready=%b, want 0 0 1",
               count, pop_valid, push_ready);
    end
    push_one(32'h0000_3000);
    #1;
    tests++;
    if (count !== 4'd1 || pop_valid !== 1'b1 || pop_pc !== 32'h0000_3000) begin
      fails++;
      $display("FAIL flush_refill: count=%0d valid=%b pc=%h, want 1 1 00003000",
               count, pop_valid, pop_pc);
    end
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc;
    for (int i = 0; i < 8; i++) begin
      push_one(32'h0000_4000 + 32'(4 * i));
    end
    push_valid = 1'b1;
    push_pc    = 32'h0000_4020;
    push_inst  = inst_of(32'h0000_4020);
    pop_ready  = 1'b1;
    #1;
    tests++;
    if (count !== 4'd8 || push_ready !== 1'b0 || pop_valid !== 1'b1 || pop_pc !== 32'h0000_4000) begin
      fails++;
      $display("FAIL full_pop_cycle: count=%0d push_ready=%b valid=%b pc=%h, want 8 0 1 00004000",
               count, push_ready, pop_valid, pop_pc);
    end
    tick();
    pop_ready = 1'b0;
    #1;
    tests++;
    if (count !== 4'd7 || push_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_pop_after: count=%0d push_ready=%b, want 7 1", count, push_ready);
    end
    tick();
    push_valid = 1'b0;
    #1;
    tests++;
    if (count !== 4'd8 || push_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_refill: count=%0d push_ready=%b, want 8 0", count, push_ready);
    end
    pop_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'h0000_4004 + 32'(4 * i);
      #1;
      tests++;
      if (pop_pc !== exp_pc) begin
        fails++;
        $display("FAIL full_pop_order_%0d: pc=%h, want %h", i, pop_pc, exp_pc);
      end
      tick();
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      push_one(32'h0000_5000 + 32'(4 * i));
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 4'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: count=%0d pop_valid=%b push_ready=%b, want 0 0 1",
               count, pop_valid, push_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill_drain();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_full_pop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
